// File: rtl/button_conditioner_pkg.sv
// Shared types and board defaults for the push-button front end that drives
// rom_reader address stepping.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_DELAY  = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_e;

    // Defaults for a 50 MHz board clock.
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES      = 50000;
    localparam int unsigned DEFAULT_REPEAT_DELAY_CYCLES  = 25000000;
    localparam int unsigned DEFAULT_REPEAT_PERIOD_CYCLES = 5000000;
    localparam logic        DEFAULT_PRESSED_LEVEL        = 1'b1;

    // Maps the raw pin onto pressed=1 regardless of board wiring.
    function automatic logic normalise_pressed(input logic raw, input logic pressed_level);
        return raw ~^ pressed_level;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debounce_repeat.sv
// One button: 2-flop synchroniser, debouncer and press/auto-repeat pulse FSM.
// pulse_o is combinational; the parent registers it.
module button_debounce_repeat
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES,
    parameter logic        PRESSED_LEVEL        = DEFAULT_PRESSED_LEVEL
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw_i,
    output logic held_o,
    output logic pulse_o
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_MAX = max_u(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_TERM     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TMR_W-1:0] DELAY_TERM  = TMR_W'(REPEAT_DELAY_CYCLES);
    localparam logic [TMR_W-1:0] PERIOD_TERM = TMR_W'(REPEAT_PERIOD_CYCLES);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              held_q, held_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic [DB_W-1:0]   cnt_inc;
    btn_state_e        state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [TMR_W-1:0]  timer_inc;
    logic              pulse;

    assign cnt_inc   = cnt_q + 1'b1;
    assign timer_inc = timer_q + 1'b1;

    always_comb begin
        sync1_d = normalise_pressed(button_raw_i, PRESSED_LEVEL);
        sync2_d = sync1_q;
    end

    // Debounce: count consecutive cycles of disagreement, accept at terminal count.
    always_comb begin
        held_d = held_q;
        cnt_d  = '0;
        if (sync2_q != held_q) begin
            if (cnt_inc == DB_TERM) begin
                held_d = ~held_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse   = 1'b0;
        if (!held_q) begin
            state_d = BTN_IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                // Held while idle can only mean it has just been accepted as pressed.
                BTN_IDLE: begin
                    pulse   = 1'b1;
                    state_d = BTN_DELAY;
                    timer_d = '0;
                end
                BTN_DELAY: begin
                    if (timer_inc == DELAY_TERM) begin
                        pulse   = 1'b1;
                        state_d = BTN_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                BTN_REPEAT: begin
                    if (timer_inc == PERIOD_TERM) begin
                        pulse   = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    state_d = BTN_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= BTN_IDLE;
            timer_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign held_o  = held_q;
    assign pulse_o = pulse;

endmodule

// File: rtl/button_conditioner.sv
// Increment/decrement button front end: two conditioned buttons, each step
// suppressed while the opposite button is held, with registered step outputs.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int unsigned REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES,
    parameter logic        PRESSED_LEVEL        = DEFAULT_PRESSED_LEVEL
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc_button_raw,
    input  logic dec_button_raw,
    output logic inc_step,
    output logic dec_step,
    output logic inc_held,
    output logic dec_held
);

    logic inc_held_w, dec_held_w;
    logic inc_pulse, dec_pulse;
    logic inc_step_q, inc_step_d;
    logic dec_step_q, dec_step_d;

    button_debounce_repeat #(
        .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
        .PRESSED_LEVEL        (PRESSED_LEVEL)
    ) u_inc (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_raw_i (inc_button_raw),
        .held_o       (inc_held_w),
        .pulse_o      (inc_pulse)
    );

    button_debounce_repeat #(
        .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
        .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
        .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
        .PRESSED_LEVEL        (PRESSED_LEVEL)
    ) u_dec (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_raw_i (dec_button_raw),
        .held_o       (dec_held_w),
        .pulse_o      (dec_pulse)
    );

    // Masking only drops pulses; the FSMs keep their own schedule, so no catch-up.
    always_comb begin
        inc_step_d = inc_pulse & ~dec_held_w;
        dec_step_d = dec_pulse & ~inc_held_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_step_q <= 1'b0;
            dec_step_q <= 1'b0;
        end else begin
            inc_step_q <= inc_step_d;
            dec_step_q <= dec_step_d;
        end
    end

    assign inc_step = inc_step_q;
    assign dec_step = dec_step_q;
    assign inc_held = inc_held_w;
    assign dec_held = dec_held_w;

`ifndef SYNTHESIS
    steps_exclusive_a: assert property (@(posedge clk) disable iff (!reset_n)
        !(inc_step_q && dec_step_q));
`endif

endmodule
